// File: rtl/sudoku_puzzle_loader.sv
// Streams one 81-cell puzzle from a synchronous ROM into the solver's load port, checking
// the solver cursor after every cell. Optional: SUDOKU_LOADER_SKIP_ZERO_EN (blanks get Next only).

module sudoku_puzzle_loader #(
    parameter int ADDR_W      = 10,
    parameter int PUZZLE_BASE = 0,
    parameter int ROM_LATENCY = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Go,
    input  logic [3:0]        PuzzleSel,
    output logic [ADDR_W-1:0] RomAddr,
    input  logic [3:0]        RomData,
    input  logic              SolverLoad,
    input  logic [3:0]        SolverRow,
    input  logic [3:0]        SolverCol,
    output logic [3:0]        InputValue,
    output logic              Enter,
    output logic              Next,
    output logic              Prev,
    output logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_ARM    = 4'd1;
    localparam logic [3:0] S_FETCH  = 4'd2;
    localparam logic [3:0] S_WAIT   = 4'd3;
    localparam logic [3:0] S_WRITE  = 4'd4;
    localparam logic [3:0] S_VERIFY = 4'd5;
    localparam logic [3:0] S_START  = 4'd6;
    localparam logic [3:0] S_DONE   = 4'd7;
    localparam logic [3:0] S_ERROR  = 4'd8;

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(PUZZLE_BASE);
    localparam logic [1:0]        WAIT_LAST = 2'(ROM_LATENCY - 1);

    logic [3:0]        state_q, state_d;
    logic [3:0]        sel_q, sel_d;
    logic [6:0]        idx_q, idx_d;
    logic [3:0]        row_q, row_d;
    logic [3:0]        col_q, col_d;
    logic [1:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [3:0]        input_value_q, input_value_d;
    logic [3:0]        nxt_row, nxt_col;

    // Modulo-2^ADDR_W arithmetic: every operand is cast to ADDR_W bits before combining.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] sel, input logic [6:0] idx);
        return BASE_ADDR + ADDR_W'(sel) * ADDR_W'(81) + ADDR_W'(idx);
    endfunction

    // Where the solver cursor must sit after the current cell is written.
    always_comb begin
        nxt_row = row_q;
        nxt_col = col_q + 4'd1;
        if (idx_q == 7'd80) begin
            nxt_row = 4'd0;
            nxt_col = 4'd0;
        end else if (col_q == 4'd8) begin
            nxt_row = row_q + 4'd1;
            nxt_col = 4'd0;
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        idx_d         = idx_q;
        row_d         = row_q;
        col_d         = col_q;
        wait_d        = wait_q;
        rom_addr_d    = rom_addr_q;
        input_value_d = input_value_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (Go) begin
                    sel_d   = PuzzleSel;
                    idx_d   = 7'd0;
                    row_d   = 4'd0;
                    col_d   = 4'd0;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                if (SolverLoad) begin
                    if (SolverRow == 4'd0 && SolverCol == 4'd0) begin
                        rom_addr_d = cell_addr(sel_q, 7'd0);
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_FETCH: begin
                wait_d  = 2'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    input_value_d = RomData;
                    state_d       = (RomData > 4'd9) ? S_ERROR : S_WRITE;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            S_WRITE: begin
                state_d = S_VERIFY;
            end
            S_VERIFY: begin
                if (SolverRow != nxt_row || SolverCol != nxt_col) begin
                    state_d = S_ERROR;
                end else if (idx_q == 7'd80) begin
                    state_d = S_START;
                end else begin
                    idx_d      = idx_q + 7'd1;
                    row_d      = nxt_row;
                    col_d      = nxt_col;
                    rom_addr_d = cell_addr(sel_q, idx_q + 7'd1);
                    state_d    = S_FETCH;
                end
            end
            S_START: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Losing LOAD mid-transfer overrides whatever the per-state logic chose.
        if (!SolverLoad && (state_q == S_FETCH || state_q == S_WAIT ||
                            state_q == S_WRITE || state_q == S_VERIFY)) begin
            state_d = S_ERROR;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            sel_q         <= 4'd0;
            idx_q         <= 7'd0;
            row_q         <= 4'd0;
            col_q         <= 4'd0;
            wait_q        <= 2'd0;
            rom_addr_q    <= BASE_ADDR;
            input_value_q <= 4'd0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            idx_q         <= idx_d;
            row_q         <= row_d;
            col_q         <= col_d;
            wait_q        <= wait_d;
            rom_addr_q    <= rom_addr_d;
            input_value_q <= input_value_d;
        end
    end

    assign RomAddr    = rom_addr_q;
    assign InputValue = input_value_q;
`ifdef SUDOKU_LOADER_SKIP_ZERO_EN
    assign Enter      = (state_q == S_WRITE) && (input_value_q != 4'd0);
`else
    assign Enter      = (state_q == S_WRITE);
`endif
    assign Next       = (state_q == S_WRITE);
    assign Prev       = 1'b0;
    assign Start      = (state_q == S_START);
    assign Busy       = (state_q >= S_ARM) && (state_q <= S_START);
    assign Done       = (state_q == S_DONE);
    assign Error      = (state_q == S_ERROR);

endmodule

// File: tb/tb_sudoku_puzzle_loader.sv
// Scoreboard bench for sudoku_puzzle_loader: a ROM model, a solver cursor model and a strobe
// monitor that pops expected cell writes; one task per scenario.

module tb_sudoku_puzzle_loader;

    localparam int AW = 10;
`ifdef SUDOKU_LOADER_SKIP_ZERO_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    val;
        logic          en;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          Go;
    logic [3:0]    PuzzleSel;
    logic [AW-1:0] RomAddr;
    logic [3:0]    RomData;
    logic          SolverLoad;
    logic [3:0]    SolverRow;
    logic [3:0]    SolverCol;
    logic [3:0]    InputValue;
    logic          Enter, Next, Prev, Start, Busy, Done, Error;

    logic [3:0]    rom_mem [1024];
    logic [3:0]    m_row = 4'd0;
    logic [3:0]    m_col = 4'd0;
    logic          fault_hold;

    exp_t          exp_q[$];
    int            checks = 0;
    int            failures = 0;
    int            enter_cnt = 0;
    int            next_cnt = 0;
    int            start_cnt = 0;
    logic [AW-1:0] first_addr, last_addr;
    bit            first_seen;

    always #5 Clk = ~Clk;

    sudoku_puzzle_loader #(.ADDR_W(AW), .PUZZLE_BASE(0), .ROM_LATENCY(1)) dut (
        .Clk(Clk), .Reset(Reset), .Go(Go), .PuzzleSel(PuzzleSel), .RomAddr(RomAddr),
        .RomData(RomData), .SolverLoad(SolverLoad), .SolverRow(SolverRow), .SolverCol(SolverCol),
        .InputValue(InputValue), .Enter(Enter), .Next(Next), .Prev(Prev), .Start(Start),
        .Busy(Busy), .Done(Done), .Error(Error)
    );

    // Synchronous ROM, one cycle from address to data.
    always @(posedge Clk) RomData <= rom_mem[RomAddr];

    // Solver cursor: advances row-major on Next; optionally sticks at column 4 after cell 4.
    always @(posedge Clk) begin
        if (Reset) begin
            m_row <= 4'd0;
            m_col <= 4'd0;
        end else if (Next === 1'b1) begin
            if (fault_hold && m_row == 4'd0 && m_col == 4'd4) begin
                m_col <= m_col;
            end else if (m_col == 4'd8) begin
                m_col <= 4'd0;
                m_row <= (m_row == 4'd8) ? 4'd0 : m_row + 4'd1;
            end else begin
                m_col <= m_col + 4'd1;
            end
        end
    end
    assign SolverRow = m_row;
    assign SolverCol = m_col;

    task automatic monitor();
        exp_t e;
        logic prev_strobe;
        logic strobe;
        prev_strobe = 1'b0;
        forever begin
            @(negedge Clk);
            strobe = (Enter === 1'b1) || (Next === 1'b1) || (Start === 1'b1);
            if (strobe) begin
                checks++;
                if (prev_strobe) begin
                    failures++;
                    $display("FAIL strobe_spacing: strobe high in consecutive cycles at %0t", $time);
                end
                checks++;
                if (Start === 1'b1 && (Enter === 1'b1 || Next === 1'b1)) begin
                    failures++;
                    $display("FAIL start_overlap: Start=%b Enter=%b Next=%b", Start, Enter, Next);
                end
                checks++;
                if (Enter === 1'b1 && Next !== 1'b1) begin
                    failures++;
                    $display("FAIL enter_without_next: Enter=%b Next=%b", Enter, Next);
                end
                checks++;
                if (Prev !== 1'b0) begin
                    failures++;
                    $display("FAIL prev_const: got %b expected 0", Prev);
                end
            end
            prev_strobe = strobe;
            if (Enter === 1'b1) enter_cnt++;
            if (Start === 1'b1) start_cnt++;
            if (Next === 1'b1) begin
                next_cnt++;
                last_addr = RomAddr;
                if (!first_seen) begin
                    first_addr = RomAddr;
                    first_seen = 1'b1;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: addr=%0d value=%0d with no write expected",
                             RomAddr, InputValue);
                end else begin
                    e = exp_q.pop_front();
                    if (RomAddr !== e.addr || InputValue !== e.val || Enter !== e.en) begin
                        failures++;
                        $display("FAIL cell_write: got addr=%0d val=%0d enter=%b expected addr=%0d val=%0d enter=%b",
                                 RomAddr, InputValue, Enter, e.addr, e.val, e.en);
                    end
                end
            end
        end
    endtask

    task automatic push_puzzle(input int sel, input int ncells, output int n_en);
        exp_t e;
        n_en = 0;
        for (int i = 0; i < ncells; i++) begin
            e.addr = AW'((sel * 81 + i) % 1024);
            e.val  = rom_mem[e.addr];
            e.en   = SKIP_ZERO ? (e.val != 4'd0) : 1'b1;
            if (e.en) n_en++;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Go = 1'b0;
        SolverLoad = 1'b1;
        fault_hold = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        exp_q.delete();
        first_seen = 1'b0;
        @(negedge Clk);
    endtask

    // Go is sampled on the posedge inside this task; callers count edges from there.
    task automatic go_pulse(input logic [3:0] sel);
        @(negedge Clk);
        Go = 1'b1;
        PuzzleSel = sel;
        @(posedge Clk);
        #1 Go = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (Done !== 1'b1 && n < 2000) begin
            @(posedge Clk);
            #1 n++;
        end
    endtask

    task automatic wait_error(output int n);
        n = 0;
        while (Error !== 1'b1 && n < 2000) begin
            @(posedge Clk);
            #1 n++;
        end
    endtask

    task automatic wait_next(input int target);
        int n;
        n = 0;
        while (next_cnt < target && n < 2000) begin
            @(posedge Clk);
            #2 n++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if (RomAddr !== 10'd0) begin
            failures++;
            $display("FAIL reset_romaddr: got %0d expected 0", RomAddr);
        end
        checks++;
        if (InputValue !== 4'd0) begin
            failures++;
            $display("FAIL reset_inputvalue: got %0d expected 0", InputValue);
        end
        checks++;
        if ({Enter, Next, Prev, Start, Busy, Done, Error} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {Enter, Next, Prev, Start, Busy, Done, Error});
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_nominal();
        int n, n_en, e0, x0, s0;
        do_reset();
        push_puzzle(0, 81, n_en);
        e0 = enter_cnt; x0 = next_cnt; s0 = start_cnt;
        go_pulse(4'd0);
        wait_done(n);
        checks++;
        if (n != 326) begin
            failures++;
            $display("FAIL nominal_latency: got %0d cycles expected 326", n);
        end
        checks++;
        if (enter_cnt - e0 != (SKIP_ZERO ? 30 : 81)) begin
            failures++;
            $display("FAIL nominal_enters: got %0d expected %0d", enter_cnt - e0, SKIP_ZERO ? 30 : 81);
        end
        checks++;
        if (next_cnt - x0 != 81) begin
            failures++;
            $display("FAIL nominal_nexts: got %0d expected 81", next_cnt - x0);
        end
        checks++;
        if (start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL nominal_start: got %0d expected 1", start_cnt - s0);
        end
        checks++;
        if (exp_q.size() != 0 || first_addr !== 10'd0 || last_addr !== 10'd80) begin
            failures++;
            $display("FAIL nominal_addrs: left=%0d first=%0d last=%0d expected left=0 first=0 last=80",
                     exp_q.size(), first_addr, last_addr);
        end
        checks++;
        if (Error !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL nominal_flags: Error=%b Busy=%b expected 0 0", Error, Busy);
        end
    endtask

    task automatic test_back_to_back();
        int n, n_en, e0, x0, s0;
        push_puzzle(1, 81, n_en);
        first_seen = 1'b0;
        e0 = enter_cnt; x0 = next_cnt; s0 = start_cnt;
        go_pulse(4'd1);
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: Done=%b Busy=%b expected 0 1", Done, Busy);
        end
        wait_done(n);
        checks++;
        if (n != 326) begin
            failures++;
            $display("FAIL b2b_latency: got %0d expected 326", n);
        end
        checks++;
        if (enter_cnt - e0 != n_en || next_cnt - x0 != 81 || start_cnt - s0 != 1) begin
            failures++;
            $display("FAIL b2b_counts: enter=%0d next=%0d start=%0d expected %0d 81 1",
                     enter_cnt - e0, next_cnt - x0, start_cnt - s0, n_en);
        end
        checks++;
        if (exp_q.size() != 0 || first_addr !== 10'd81) begin
            failures++;
            $display("FAIL b2b_addrs: left=%0d first=%0d expected 0 81", exp_q.size(), first_addr);
        end
    endtask

    task automatic test_reset_mid_load();
        int n, n_en, x0, s0;
        do_reset();
        push_puzzle(0, 11, n_en);
        x0 = next_cnt;
        go_pulse(4'd0);
        wait_next(x0 + 10);
        repeat (3) begin
            @(posedge Clk);
            #2;
        end
        checks++;
        if (Next !== 1'b1) begin
            failures++;
            $display("FAIL midload_in_write: Next=%b expected 1", Next);
        end
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        checks++;
        if ({Enter, Next, Prev, Start, Busy, Done, Error} !== 7'b0 || RomAddr !== 10'd0 ||
            InputValue !== 4'd0) begin
            failures++;
            $display("FAIL midload_reset: flags=%b addr=%0d val=%0d expected 0000000 0 0",
                     {Enter, Next, Prev, Start, Busy, Done, Error}, RomAddr, InputValue);
        end
        Reset = 1'b0;
        repeat (10) @(negedge Clk);
        checks++;
        if (next_cnt - x0 != 11 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL midload_quiet: nexts=%0d left=%0d expected 11 0", next_cnt - x0, exp_q.size());
        end
        push_puzzle(3, 81, n_en);
        first_seen = 1'b0;
        s0 = start_cnt;
        go_pulse(4'd3);
        wait_done(n);
        checks++;
        if (first_addr !== 10'd243 || last_addr !== 10'd323) begin
            failures++;
            $display("FAIL sel3_addrs: first=%0d last=%0d expected 243 323", first_addr, last_addr);
        end
        checks++;
        if (start_cnt - s0 != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL sel3_done: starts=%0d left=%0d expected 1 0", start_cnt - s0, exp_q.size());
        end
    endtask

    task automatic test_puzzle_sel12();
        int n, n_en, x0, s0;
        do_reset();
        SolverLoad = 1'b0;
        push_puzzle(12, 81, n_en);
        x0 = next_cnt; s0 = start_cnt;
        go_pulse(4'd12);
        repeat (6) @(negedge Clk);
        checks++;
        if (Busy !== 1'b1 || next_cnt != x0) begin
            failures++;
            $display("FAIL arm_wait: Busy=%b nexts=%0d expected 1 0", Busy, next_cnt - x0);
        end
        SolverLoad = 1'b1;
        wait_next(x0 + 3);
        @(negedge Clk);
        Go = 1'b1;
        PuzzleSel = 4'd0;
        @(negedge Clk);
        Go = 1'b0;
        wait_done(n);
        checks++;
        if (first_addr !== 10'd972 || last_addr !== 10'd28) begin
            failures++;
            $display("FAIL sel12_wrap: first=%0d last=%0d expected 972 28", first_addr, last_addr);
        end
        checks++;
        if (next_cnt - x0 != 81 || start_cnt - s0 != 1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL sel12_counts: nexts=%0d starts=%0d left=%0d expected 81 1 0",
                     next_cnt - x0, start_cnt - s0, exp_q.size());
        end
    endtask

    task automatic test_cursor_fault();
        int n, n_en, e0, x0, s0;
        do_reset();
        fault_hold = 1'b1;
        push_puzzle(0, 5, n_en);
        e0 = enter_cnt; x0 = next_cnt; s0 = start_cnt;
        go_pulse(4'd0);
        wait_error(n);
        checks++;
        if (n != 21) begin
            failures++;
            $display("FAIL cursor_fault_time: got %0d cycles expected 21", n);
        end
        repeat (20) @(negedge Clk);
        checks++;
        if (next_cnt - x0 != 5 || enter_cnt - e0 != n_en || start_cnt != s0) begin
            failures++;
            $display("FAIL cursor_fault_strobes: nexts=%0d enters=%0d starts=%0d expected 5 %0d 0",
                     next_cnt - x0, enter_cnt - e0, start_cnt - s0, n_en);
        end
        checks++;
        if (Error !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL cursor_fault_flags: Error=%b Busy=%b Done=%b expected 1 0 0", Error, Busy, Done);
        end
        fault_hold = 1'b0;
    endtask

    task automatic test_bad_data();
        int n, n_en, x0, s0;
        logic [3:0] saved;
        saved = rom_mem[20];
        rom_mem[20] = 4'hB;
        do_reset();
        push_puzzle(0, 20, n_en);
        x0 = next_cnt; s0 = start_cnt;
        go_pulse(4'd0);
        wait_error(n);
        checks++;
        if (n != 83) begin
            failures++;
            $display("FAIL bad_data_time: got %0d cycles expected 83", n);
        end
        repeat (10) @(negedge Clk);
        checks++;
        if (next_cnt - x0 != 20 || start_cnt != s0 || exp_q.size() != 0 || Error !== 1'b1) begin
            failures++;
            $display("FAIL bad_data: nexts=%0d starts=%0d left=%0d Error=%b expected 20 0 0 1",
                     next_cnt - x0, start_cnt - s0, exp_q.size(), Error);
        end
        rom_mem[20] = saved;
    endtask

    task automatic test_lost_load();
        int n, n_en, x0, s0;
        do_reset();
        push_puzzle(0, 50, n_en);
        x0 = next_cnt; s0 = start_cnt;
        go_pulse(4'd0);
        wait_next(x0 + 50);
        @(posedge Clk);
        #2 SolverLoad = 1'b0;
        wait_error(n);
        checks++;
        if (n != 1) begin
            failures++;
            $display("FAIL lost_load_time: got %0d cycles expected 1", n);
        end
        repeat (10) @(negedge Clk);
        checks++;
        if (next_cnt - x0 != 50 || start_cnt != s0 || exp_q.size() != 0 || Error !== 1'b1) begin
            failures++;
            $display("FAIL lost_load: nexts=%0d starts=%0d left=%0d Error=%b expected 50 0 0 1",
                     next_cnt - x0, start_cnt - s0, exp_q.size(), Error);
        end
        SolverLoad = 1'b1;
    endtask

    initial begin
        Reset = 1'b1;
        Go = 1'b0;
        PuzzleSel = 4'd0;
        SolverLoad = 1'b1;
        fault_hold = 1'b0;
        first_seen = 1'b0;
        // Exactly 30 givens per aligned puzzle since 7 is coprime with 81.
        for (int a = 0; a < 1024; a++) begin
            rom_mem[a] = (((a * 7) % 81) < 30) ? 4'((a % 9) + 1) : 4'd0;
        end
        fork
            monitor();
        join_none
        test_reset();
        test_nominal();
        test_back_to_back();
        test_reset_mid_load();
        test_puzzle_sel12();
        test_cursor_fault();
        test_bad_data();
        test_lost_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
